sysid_checker_master: RTL and testbench

- Avalon-MM read master that fetches the two 32-bit words of the system-ID slave and compares them against expected values.
  - Word 0 is the ID; word 1 is the build timestamp.
- Sits beside the Nios II on the system interconnect.
- Runs automatically after reset or on software/host request.
- Result drives a "hardware/software image match" status bit and an LED.

---
 rtl/sysid_checker_pkg.sv | 18 +
 rtl/sysid_word_reader.sv | 74 +++++++
 rtl/sysid_checker_master.sv | 135 +++++++++++++
 tb/tb_sysid_checker_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system-ID checker.
package sysid_checker_pkg;

    localparam int DATA_W = 32;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID_REQ,
        RD_ID_WAIT,
        RD_TS_REQ,
        RD_TS_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/sysid_word_reader.sv
// sysid_word_reader: one Avalon-MM read handshake (request, then wait for readdatavalid).
// With SYSID_CHECK_TIMEOUT_EN a 16-bit counter aborts a request or wait phase that runs too long.
module sysid_word_reader
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic issue,
    input  logic issue_addr,
    output logic avm_address,
    output logic avm_read,
    input  logic avm_waitrequest,
    input  logic avm_readdatavalid,
    output logic accepted,
    output logic data_valid,
    output logic timed_out
);

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
        $error("sysid_word_reader: TIMEOUT_CYCLES must be at least 2");
    end

    logic read_q, read_d;
    logic addr_q, addr_d;
    logic wait_q, wait_d;
    logic tmo;

    assign accepted    = read_q & ~avm_waitrequest;
    assign data_valid  = wait_q & avm_readdatavalid;
    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign timed_out   = tmo;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // A phase that completes on its final allowed cycle is not treated as a timeout.
    assign tmo = (read_q | wait_q) & (cnt_q == TMO_LAST) & ~accepted & ~data_valid;

    always_comb begin
        cnt_d = (issue | accepted) ? 16'd0 : (read_q | wait_q) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= 16'd0;
        else          cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        read_d = issue | (read_q & avm_waitrequest & ~tmo);
        wait_d = accepted | (wait_q & ~avm_readdatavalid & ~tmo);
        addr_d = issue ? issue_addr : addr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_q <= 1'b0;
            wait_q <= 1'b0;
            addr_q <= ADDR_ID;
        end else begin
            read_q <= read_d;
            wait_q <= wait_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/sysid_checker_master.sv
// sysid_checker_master: reads system-ID words 0 (ID) and 1 (timestamp) and compares them to expected values.
// Optional build macro SYSID_CHECK_TIMEOUT_EN enables the per-transaction timeout.
module sysid_checker_master
    import sysid_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1427262868,
    parameter int                AUTO_START     = 1,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              id_match,
    output logic              ts_match,
    output logic              pass,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    output logic              timeout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] id_value_q, id_value_d;
    logic [DATA_W-1:0] ts_value_q, ts_value_d;
    logic              id_match_q, id_match_d;
    logic              ts_match_q, ts_match_d;
    logic              timeout_q, timeout_d;
    logic              auto_q, auto_d;
    logic              issue, issue_addr;
    logic              accepted, data_valid, timed_out;

    sysid_word_reader #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_reader (
        .clock            (clock),
        .reset_n          (reset_n),
        .issue            (issue),
        .issue_addr       (issue_addr),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .accepted         (accepted),
        .data_valid       (data_valid),
        .timed_out        (timed_out)
    );

    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        timeout_d  = timeout_q;
        auto_d     = 1'b0;
        issue      = 1'b0;
        issue_addr = ADDR_ID;
        case (state_q)
            IDLE, DONE: begin
                if (start || auto_q) begin
                    state_d    = RD_ID_REQ;
                    issue      = 1'b1;
                    id_value_d = '0;
                    ts_value_d = '0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            RD_ID_REQ:  if (accepted) state_d = RD_ID_WAIT;
            RD_ID_WAIT: begin
                if (data_valid) begin
                    state_d    = RD_TS_REQ;
                    id_value_d = avm_readdata;
                    issue      = 1'b1;
                    issue_addr = ADDR_TS;
                end
            end
            RD_TS_REQ:  if (accepted) state_d = RD_TS_WAIT;
            RD_TS_WAIT: begin
                if (data_valid) begin
                    state_d    = DONE;
                    ts_value_d = avm_readdata;
                    id_match_d = (id_value_q == EXPECTED_ID);
                    ts_match_d = (avm_readdata == EXPECTED_TS);
                end
            end
            default:    state_d = IDLE;
        endcase
        // The ID word is only valid if the abort happened during the timestamp read.
        if (timed_out) begin
            state_d    = DONE;
            timeout_d  = 1'b1;
            id_match_d = (state_q == RD_TS_REQ || state_q == RD_TS_WAIT) && (id_value_q == EXPECTED_ID);
            ts_match_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            auto_q     <= (AUTO_START != 0);
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            timeout_q  <= timeout_d;
            auto_q     <= auto_d;
        end
    end

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign id_match = id_match_q;
    assign ts_match = ts_match_q;
    assign pass     = done & id_match_q & ts_match_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_sysid_checker_master.sv
// tb_sysid_checker_master: table, directed and random checks of the system-ID checker against a reactive Avalon slave.
module tb_sysid_checker_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1427262868;
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_match, ts_match, pass, timeout;
    logic [31:0] id_value, ts_value;

    sysid_checker_master #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .AUTO_START    (1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_match         (id_match),
        .ts_match         (ts_match),
        .pass             (pass),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Slave configuration (written by the stimulus only)
    int          ws_cfg = 0;
    int          lat_cfg = 1;
    logic [31:0] mem [2];
    bit          spur_req = 1'b0;
    int          inject_req = 0;

    // Slave state (written by the slave only)
    int          accepts = 0;
    int          viol = 0;
    int          inject_done = 0;
    int          stall_n = 0;
    bit          was_stalled = 1'b0;
    logic        stall_addr = 1'b0;
    bit          pend_on = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;

    // Slave drives at the falling edge what the next rising edge will see.
    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (pend_on) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = pend_data;
                pend_on = 1'b0;
            end
        end
        if (inject_req != inject_done) begin
            inject_done = inject_req;
            avm_readdatavalid = 1'b1;
            avm_readdata = 32'hDEAD_BEEF;
        end
        if (was_stalled && !timeout && (!avm_read || avm_address != stall_addr)) viol++;
        if (avm_read) begin
            if (stall_n < ws_cfg) begin
                avm_waitrequest = 1'b1;
                stall_n++;
                was_stalled = 1'b1;
                stall_addr = avm_address;
                if (spur_req) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = 32'hDEAD_BEEF;
                end
            end else begin
                avm_waitrequest = 1'b0;
                was_stalled = 1'b0;
                stall_n = 0;
                if (pend_on) viol++;
                pend_on = 1'b1;
                pend_cnt = lat_cfg;
                pend_data = mem[avm_address];
                accepts++;
            end
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
            was_stalled = 1'b0;
            stall_n = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference timing: launch cycle, then (stalls + 1) request cycles and lat wait cycles per word.
    function automatic int exp_cycles(input int ws, input int lat);
        return 1 + 2 * (ws + 1 + lat);
    endfunction

    // Called at a falling edge; launches by start pulse or by releasing reset (auto-start).
    task automatic launch(input bit use_start, output int cyc, output logic busy1);
        if (use_start) start = 1'b1;
        else reset_n = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        busy1 = busy;
        while (!done && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_check(input string nm, input int ws, input int lat,
                             input logic [31:0] w0, input logic [31:0] w1, input bit use_start,
                             input bit e_idm, input bit e_tsm, input bit e_pass, input int e_cyc);
        int cyc, base;
        logic b1;
        ws_cfg = ws;
        lat_cfg = lat;
        mem[0] = w0;
        mem[1] = w1;
        base = accepts;
        launch(use_start, cyc, b1);
        chk({nm, " cycles_to_done"}, 64'(cyc), 64'(e_cyc));
        chk({nm, " busy_after_launch"}, 64'(b1), 64'd1);
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, " id_value"}, 64'(id_value), 64'(w0));
        chk({nm, " ts_value"}, 64'(ts_value), 64'(w1));
        chk({nm, " id_match"}, 64'(id_match), 64'(e_idm));
        chk({nm, " ts_match"}, 64'(ts_match), 64'(e_tsm));
        chk({nm, " pass"}, 64'(pass), 64'(e_pass));
        chk({nm, " timeout"}, 64'(timeout), 64'd0);
        chk({nm, " reads_accepted"}, 64'(accepts - base), 64'd2);
    endtask

    typedef struct {
        int          ws;
        int          lat;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          idm;
        bit          tsm;
        bit          ps;
        int          cyc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, dc, base;
        logic b1, found;
        logic [31:0] w0, w1;
        int ws, lat;

        tbl[0] = '{ws: 0, lat: 1, w0: 32'd0, w1: 32'd1427262869, idm: 1, tsm: 0, ps: 0, cyc: 5};
        tbl[1] = '{ws: 3, lat: 4, w0: 32'd0, w1: 32'd1427262868, idm: 1, tsm: 1, ps: 1, cyc: 17};
        tbl[2] = '{ws: 0, lat: 1, w0: 32'd5, w1: 32'd1427262868, idm: 0, tsm: 1, ps: 0, cyc: 5};
        tbl[3] = '{ws: 1, lat: 2, w0: 32'hFFFF_FFFF, w1: 32'd0, idm: 0, tsm: 0, ps: 0, cyc: 9};
        tbl[4] = '{ws: 2, lat: 1, w0: 32'd0, w1: 32'd1427262868, idm: 1, tsm: 1, ps: 1, cyc: 9};
        tbl[5] = '{ws: 0, lat: 3, w0: 32'h8000_0000, w1: 32'd1427262868, idm: 0, tsm: 1, ps: 0, cyc: 9};

        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        repeat (3) @(negedge clock);
        chk("reset flags", {56'd0, avm_read, avm_address, busy, done, id_match, ts_match, pass, timeout}, 64'd0);
        chk("reset id_value", 64'(id_value), 64'd0);
        chk("reset ts_value", 64'(ts_value), 64'd0);

        run_check("auto_start", 0, 1, EXP_ID, EXP_TS, 1'b0, 1, 1, 1, 5);

        for (int i = 0; i < 6; i++)
            run_check($sformatf("table[%0d]", i), tbl[i].ws, tbl[i].lat, tbl[i].w0, tbl[i].w1, 1'b1,
                      tbl[i].idm, tbl[i].tsm, tbl[i].ps, tbl[i].cyc);

        // Starts while busy, a start on the DONE-entry cycle, and spurious readdatavalid outside WAIT.
        ws_cfg = 2;
        lat_cfg = 3;
        mem[0] = EXP_ID;
        mem[1] = EXP_TS;
        spur_req = 1'b1;
        base = accepts;
        dc = 0;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            if (done && dc == 0) dc = c;
            start = ((c % 2 == 1) && c < 8) || c == exp_cycles(2, 3) - 1;
        end
        start = 1'b0;
        spur_req = 1'b0;
        chk("busy_starts cycles_to_done", 64'(dc), 64'(exp_cycles(2, 3)));
        chk("busy_starts done_held", 64'(done), 64'd1);
        chk("busy_starts reads_accepted", 64'(accepts - base), 64'd2);
        chk("busy_starts id_value", 64'(id_value), 64'(EXP_ID));
        chk("busy_starts ts_value", 64'(ts_value), 64'(EXP_TS));
        chk("busy_starts pass", 64'(pass), 64'd1);
        inject_req++;
        repeat (2) @(negedge clock);
        chk("spurious_done id_value", 64'(id_value), 64'(EXP_ID));
        chk("spurious_done ts_value", 64'(ts_value), 64'(EXP_TS));
        chk("spurious_done done", 64'(done), 64'd1);
        chk("spurious_done reads_accepted", 64'(accepts - base), 64'd2);

        run_check("relaunch", 0, 1, EXP_ID, EXP_TS, 1'b1, 1, 1, 1, 5);

        // Reset during the timestamp wait; the aborted read's data arrives during the next request stall.
        ws_cfg = 0;
        lat_cfg = 6;
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            start = 1'b0;
            found = busy && avm_address && !avm_read;
        end
        chk("abort reached_ts_wait", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort flags", {56'd0, avm_read, avm_address, busy, done, id_match, ts_match, pass, timeout}, 64'd0);
        chk("abort id_value", 64'(id_value), 64'd0);
        chk("abort ts_value", 64'(ts_value), 64'd0);
        repeat (2) @(negedge clock);
        run_check("after_abort", 3, 1, EXP_ID, EXP_TS, 1'b0, 1, 1, 1, exp_cycles(3, 1));

        for (int i = 0; i < 30; i++) begin
            ws = $urandom_range(0, 3);
            lat = $urandom_range(1, 4);
            w0 = $urandom_range(0, 1) ? EXP_ID : 32'($urandom);
            w1 = $urandom_range(0, 1) ? EXP_TS : EXP_TS ^ (32'd1 << $urandom_range(0, 31));
            run_check($sformatf("random[%0d]", i), ws, lat, w0, w1, 1'b1,
                      w0 == EXP_ID, w1 == EXP_TS, (w0 == EXP_ID) && (w1 == EXP_TS), exp_cycles(ws, lat));
        end

`ifdef SYSID_CHECK_TIMEOUT_EN
        ws_cfg = 1000;
        base = accepts;
        launch(1'b1, cyc, b1);
        chk("timeout cycles_to_done", 64'(cyc), 64'(1 + TMO));
        chk("timeout flag", 64'(timeout), 64'd1);
        chk("timeout done", 64'(done), 64'd1);
        chk("timeout pass", 64'(pass), 64'd0);
        chk("timeout id_match", 64'(id_match), 64'd0);
        chk("timeout ts_match", 64'(ts_match), 64'd0);
        chk("timeout avm_read", 64'(avm_read), 64'd0);
        chk("timeout busy", 64'(busy), 64'd0);
        chk("timeout reads_accepted", 64'(accepts - base), 64'd0);
        run_check("after_timeout", 0, 1, EXP_ID, EXP_TS, 1'b1, 1, 1, 1, 5);
`endif

        chk("handshake_violations", 64'(viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
